// File: rtl/pcs_pkg.sv
// ============================================================================
// pcs_pkg : shared sync-header constants, header check and lock-FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [2:0] {
    LOCK_INIT = 3'd0,
    RESET_CNT = 3'd1,
    TEST_SH   = 3'd2,
    GOOD_64   = 3'd3,
    SLIP      = 3'd4
  } lock_state_t;

  function automatic logic is_valid_header(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcs_block_lock.sv
// ============================================================================
// pcs_block_lock : 64b/66b receive block-lock FSM with bit-slip request
// Revision: 1.0
// ============================================================================
`default_nettype none

module pcs_block_lock
  import pcs_pkg::*;
#(
  parameter int LOCK_COUNT       = 64,
  parameter int SH_WINDOW        = 64,
  parameter int INVALID_LIMIT    = 16,
  parameter int SLIP_WAIT_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_signal_ok,
  input  logic [1:0] i_header,
  input  logic       i_header_valid,
  output logic       o_block_lock,
  output logic       o_slip,
  output logic [4:0] o_sh_invalid_cnt
);

  localparam logic [6:0] LOCK_CNT_W  = 7'(LOCK_COUNT);
  localparam logic [6:0] WINDOW_W    = 7'(SH_WINDOW);
  localparam logic [4:0] LIMIT_W     = 5'(INVALID_LIMIT);
  localparam logic [7:0] SLIP_WAIT_W = 8'(SLIP_WAIT_CYCLES);

  lock_state_t state;
  logic        block_lock;
  logic        slip;
  logic [6:0]  sh_cnt;
  logic [4:0]  sh_invalid_cnt;
  logic [7:0]  slip_wait;

  logic        test_now;
  logic        hdr_bad;
  logic [6:0]  sh_cnt_next;
  logic [4:0]  inv_next;
  logic [6:0]  good_target;

  assign test_now    = i_header_valid && (state == TEST_SH) && (slip_wait == 8'd0);
  assign hdr_bad     = !is_valid_header(i_header);
  assign sh_cnt_next = sh_cnt + 7'd1;
  assign inv_next    = sh_invalid_cnt + {4'd0, hdr_bad};
  // Acquiring lock and policing an established lock may use different lengths.
  assign good_target = block_lock ? WINDOW_W : LOCK_CNT_W;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= LOCK_INIT;
      block_lock     <= 1'b0;
      slip           <= 1'b0;
      sh_cnt         <= 7'd0;
      sh_invalid_cnt <= 5'd0;
      slip_wait      <= 8'd0;
    end else if (!i_signal_ok) begin
      state      <= LOCK_INIT;
      block_lock <= 1'b0;
      slip       <= 1'b0;
      slip_wait  <= 8'd0;
    end else begin
      slip <= 1'b0;
      if (slip_wait != 8'd0) slip_wait <= slip_wait - 8'd1;
      case (state)
        LOCK_INIT: begin
          block_lock <= 1'b0;
          state      <= RESET_CNT;
        end
        RESET_CNT: begin
          sh_cnt         <= 7'd0;
          sh_invalid_cnt <= 5'd0;
          state          <= TEST_SH;
        end
        TEST_SH: begin
          if (test_now) begin
            sh_cnt         <= sh_cnt_next;
            sh_invalid_cnt <= inv_next;
            // Slip outputs are raised on entry so they appear one cycle after the bad header.
            if (hdr_bad && (!block_lock || inv_next == LIMIT_W)) begin
              state      <= SLIP;
              slip       <= 1'b1;
              block_lock <= 1'b0;
            end else if (sh_cnt_next == good_target && inv_next == 5'd0) begin
              state <= GOOD_64;
            end else if (sh_cnt_next == WINDOW_W && inv_next != 5'd0) begin
              state <= RESET_CNT;
            end
          end
        end
        GOOD_64: begin
          block_lock <= 1'b1;
          state      <= RESET_CNT;
        end
        SLIP: begin
          slip_wait <= SLIP_WAIT_W;
          state     <= RESET_CNT;
        end
        default: state <= LOCK_INIT;
      endcase
    end
  end

  assign o_block_lock     = block_lock;
  assign o_slip           = slip;
  assign o_sh_invalid_cnt = sh_invalid_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pcs_block_lock.sv
// ============================================================================
// tb_pcs_block_lock : randomized scenarios checked against a timeline model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pcs_block_lock;

  localparam int LOCK_COUNT       = 64;
  localparam int SH_WINDOW        = 64;
  localparam int INVALID_LIMIT    = 16;
  localparam int SLIP_WAIT_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       signal_ok;
  logic [1:0] header;
  logic       header_valid;
  logic       block_lock;
  logic       slip;
  logic [4:0] inv_cnt;

  int total = 0;
  int bad   = 0;

  // Timeline model: visible outputs plus "deaf" cycles and scheduled events.
  bit m_lock, m_slip;
  int m_cnt, m_inv, m_deaf, m_clr_in, m_lockset_in;

  pcs_block_lock #(
    .LOCK_COUNT(LOCK_COUNT), .SH_WINDOW(SH_WINDOW),
    .INVALID_LIMIT(INVALID_LIMIT), .SLIP_WAIT_CYCLES(SLIP_WAIT_CYCLES)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_signal_ok(signal_ok),
    .i_header(header), .i_header_valid(header_valid),
    .o_block_lock(block_lock), .o_slip(slip), .o_sh_invalid_cnt(inv_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lock = 0; m_slip = 0; m_cnt = 0; m_inv = 0;
    m_deaf = 2; m_clr_in = 0; m_lockset_in = 0;
  endtask

  task automatic model_step(input bit ok, input bit hv, input logic [1:0] h);
    bit is_bad;
    is_bad = !(h == 2'b01 || h == 2'b10);
    if (!ok) begin
      m_lock = 0; m_slip = 0; m_deaf = 2; m_clr_in = 2; m_lockset_in = 0;
      return;
    end
    m_slip = 0;
    if (m_lockset_in > 0) begin m_lockset_in--; if (m_lockset_in == 0) m_lock = 1; end
    if (m_clr_in > 0) begin m_clr_in--; if (m_clr_in == 0) begin m_cnt = 0; m_inv = 0; end end
    if (m_deaf > 0) m_deaf--;
    else if (hv) begin
      m_cnt++;
      if (is_bad) m_inv++;
      if (is_bad && (!m_lock || m_inv == INVALID_LIMIT)) begin
        m_slip = 1; m_lock = 0; m_deaf = 1 + SLIP_WAIT_CYCLES; m_clr_in = 2;
      end else if (m_inv == 0 && m_cnt == (m_lock ? SH_WINDOW : LOCK_COUNT)) begin
        m_deaf = 2; m_clr_in = 2; m_lockset_in = 1;
      end else if (m_inv != 0 && m_cnt == SH_WINDOW) begin
        m_deaf = 1; m_clr_in = 1;
      end
    end
  endtask

  function automatic logic [1:0] rand_hdr(input bit make_bad);
    logic [1:0] v;
    v = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    if (make_bad) v = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    return v;
  endfunction

  task automatic tick(input bit ok, input bit hv, input logic [1:0] h);
    @(negedge clk);
    signal_ok = ok; header_valid = hv; header = h;
    @(posedge clk);
    model_step(ok, hv, h);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; signal_ok = 1'b1; header_valid = 1'b0; header = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (block_lock !== 1'b0 || slip !== 1'b0 || inv_cnt !== 5'd0) begin
      bad++; $display("FAIL reset_state lock=%b slip=%b inv=%0d expected 0/0/0", block_lock, slip, inv_cnt);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 2'b00);
      total++;
      if (block_lock !== m_lock || slip !== m_slip || inv_cnt !== m_inv[4:0]) begin
        bad++; $display("FAIL reset_idle t=%0t lock=%b/%b slip=%b/%b inv=%0d/%0d", $time, block_lock, m_lock, slip, m_slip, inv_cnt, m_inv);
      end
    end
  endtask

  task automatic acquire_lock(input bit back_to_back);
    int slips = 0;
    for (int i = 0; i < 400 && !m_lock; i++) begin
      tick(1, back_to_back || (i % 2 == 0), rand_hdr(0));
      if (slip === 1'b1) slips++;
      total++;
      if (block_lock !== m_lock || slip !== m_slip || inv_cnt !== m_inv[4:0]) begin
        bad++; $display("FAIL acquire t=%0t lock=%b/%b slip=%b/%b inv=%0d/%0d", $time, block_lock, m_lock, slip, m_slip, inv_cnt, m_inv);
      end
    end
    repeat (3) tick(1, 0, 2'b00);
    total++;
    if (block_lock !== 1'b1 || slips != 0) begin
      bad++; $display("FAIL acquire_end lock=%b slips=%0d required lock=1 slips=0", block_lock, slips);
    end
  endtask

  task automatic test_slip_unlocked();
    bit sent = 0;
    bit tested, b;
    int slips = 0;
    tick(0, 0, 2'b00);
    for (int i = 0; i < 500 && !(sent && m_lock); i++) begin
      tested = (i % 2 == 0) && (m_deaf == 0);
      b = tested && !sent && (m_cnt == 9);
      tick(1, i % 2 == 0, rand_hdr(b));
      if (slip === 1'b1) slips++;
      total++;
      if (block_lock !== m_lock || slip !== m_slip || inv_cnt !== m_inv[4:0]) begin
        bad++; $display("FAIL slip_unlocked t=%0t lock=%b/%b slip=%b/%b inv=%0d/%0d", $time, block_lock, m_lock, slip, m_slip, inv_cnt, m_inv);
      end
      if (b) begin
        sent = 1;
        total++;
        if (slip !== 1'b1 || block_lock !== 1'b0) begin
          bad++; $display("FAIL slip_pulse slip=%b lock=%b required 1/0", slip, block_lock);
        end
      end
    end
    repeat (3) tick(1, 0, 2'b00);
    total++;
    if (slips != 1 || block_lock !== 1'b1) begin
      bad++; $display("FAIL slip_relock slips=%0d lock=%b required 1/1", slips, block_lock);
    end
  endtask

  task automatic test_locked_window();
    int need, slots, ta;
    bit tested, b;
    bit fired = 0;
    for (int phase = 0; phase < 2; phase++) begin
      ta = 0;
      for (int i = 0; i < 400 && ta < SH_WINDOW && !fired; i++) begin
        tested = (i % 2 == 0) && (m_deaf == 0);
        need = (phase == 0 ? INVALID_LIMIT - 1 : INVALID_LIMIT) - m_inv;
        slots = SH_WINDOW - m_cnt;
        b = tested && need > 0 && (need >= slots || $urandom_range(0, 3) == 0);
        tick(1, i % 2 == 0, rand_hdr(b));
        if (tested) ta++;
        total++;
        if (block_lock !== m_lock || slip !== m_slip || inv_cnt !== m_inv[4:0]) begin
          bad++; $display("FAIL locked_window t=%0t lock=%b/%b slip=%b/%b inv=%0d/%0d", $time, block_lock, m_lock, slip, m_slip, inv_cnt, m_inv);
        end
        if (phase == 1 && b && need == 1) begin
          fired = 1;
          total++;
          if (slip !== 1'b1 || block_lock !== 1'b0) begin
            bad++; $display("FAIL limit_slip slip=%b lock=%b required 1/0", slip, block_lock);
          end
        end
      end
      repeat (3) tick(1, 0, 2'b00);
      if (phase == 0) begin
        total++;
        if (block_lock !== 1'b1 || inv_cnt !== 5'd0) begin
          bad++; $display("FAIL window_15 lock=%b inv=%0d required 1/0", block_lock, inv_cnt);
        end
      end
    end
    total++;
    if (!fired || block_lock !== 1'b0) begin
      bad++; $display("FAIL window_16 fired=%b lock=%b required 1/0", fired, block_lock);
    end
  endtask

  task automatic test_sparse_invalid();
    int pos = $urandom_range(0, SH_WINDOW - 1);
    int ta = 0, drops = 0;
    bit tested, b;
    acquire_lock(0);
    for (int i = 0; i < 2000 && ta < 10 * SH_WINDOW; i++) begin
      tested = (i % 2 == 0) && (m_deaf == 0);
      b = tested && (m_cnt == pos);
      tick(1, i % 2 == 0, rand_hdr(b));
      if (tested) begin
        ta++;
        if (ta % SH_WINDOW == 0) pos = $urandom_range(0, SH_WINDOW - 1);
      end
      if (block_lock !== 1'b1) drops++;
      total++;
      if (block_lock !== m_lock || slip !== m_slip || inv_cnt !== m_inv[4:0]) begin
        bad++; $display("FAIL sparse t=%0t lock=%b/%b slip=%b/%b inv=%0d/%0d", $time, block_lock, m_lock, slip, m_slip, inv_cnt, m_inv);
      end
    end
    total++;
    if (drops != 0 || ta != 10 * SH_WINDOW) begin
      bad++; $display("FAIL sparse_hold drops=%0d windows_hdrs=%0d required 0/%0d", drops, ta, 10 * SH_WINDOW);
    end
  endtask

  task automatic test_signal_loss();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, rand_hdr(0));
      total++;
      if (block_lock !== 1'b0 || slip !== 1'b0 || block_lock !== m_lock) begin
        bad++; $display("FAIL signal_loss cyc=%0d lock=%b slip=%b required 0/0", i, block_lock, slip);
      end
    end
    acquire_lock(0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 600; i++) begin
      tick(1, $urandom_range(0, 7) != 0, rand_hdr($urandom_range(0, 24) == 0));
      total++;
      if (block_lock !== m_lock || slip !== m_slip || inv_cnt !== m_inv[4:0]) begin
        bad++; $display("FAIL back_to_back t=%0t lock=%b/%b slip=%b/%b inv=%0d/%0d", $time, block_lock, m_lock, slip, m_slip, inv_cnt, m_inv);
      end
    end
    acquire_lock(1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 40; i++) begin
      tick(1, i % 2 == 0, rand_hdr(i == 10));
      total++;
      if (block_lock !== m_lock || slip !== m_slip || inv_cnt !== m_inv[4:0]) begin
        bad++; $display("FAIL pre_reset t=%0t lock=%b/%b slip=%b/%b inv=%0d/%0d", $time, block_lock, m_lock, slip, m_slip, inv_cnt, m_inv);
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (block_lock !== 1'b0 || slip !== 1'b0 || inv_cnt !== 5'd0) begin
      bad++; $display("FAIL async_reset lock=%b slip=%b inv=%0d required 0/0/0", block_lock, slip, inv_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 2'b00);
      total++;
      if (block_lock !== m_lock || slip !== m_slip || inv_cnt !== m_inv[4:0]) begin
        bad++; $display("FAIL post_reset t=%0t lock=%b/%b slip=%b/%b inv=%0d/%0d", $time, block_lock, m_lock, slip, m_slip, inv_cnt, m_inv);
      end
    end
    acquire_lock(0);
  endtask

  initial begin
    test_reset();
    acquire_lock(0);
    test_slip_unlocked();
    test_locked_window();
    test_sparse_invalid();
    test_signal_loss();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
